// File: rtl/serial_link_channel_compactor.sv
// Serial link TX channel compactor: re-packs full-width beats onto the enabled
// physical channels, serialising a beat over several cycles when channels are missing.
package serial_link_pkg;
  localparam int NumChannels = 4;
  typedef logic [15:0] phy_data_t;
endpackage

module serial_link_channel_compactor #(
  parameter type phy_data_t  = serial_link_pkg::phy_data_t,
  parameter int  NumChannels = serial_link_pkg::NumChannels
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic      [NumChannels-1:0] cfg_ch_en_i,
  input  logic                        cfg_bypass_i,
  input  logic                        cfg_flush_i,
  input  phy_data_t [NumChannels-1:0] data_in_i,
  input  logic      [NumChannels-1:0] data_in_valid_i,
  output logic                        data_in_ready_o,
  output phy_data_t [NumChannels-1:0] data_out_o,
  output logic      [NumChannels-1:0] data_out_valid_o,
  input  logic                        data_out_ready_i
);

  localparam int IW = $clog2(NumChannels) + 1;
  localparam int LW = $clog2(NumChannels);
  localparam logic [IW-1:0] NW  = IW'(NumChannels);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                        r_state;
  logic      [IW-1:0]            r_idx;
  logic      [NumChannels-1:0]   r_mask;
  phy_data_t [NumChannels-1:0]   r_hold;

  logic      [IW-1:0]            w_k;
  logic      [IW-1:0]            w_k_live;
  logic      [IW-1:0]            w_slot;
  logic      [IW-1:0]            w_word;
  logic                          w_last;
  logic                          w_accept;
  phy_data_t [NumChannels-1:0]   w_data;
  logic      [NumChannels-1:0]   w_valid;

  function automatic logic [IW-1:0] popcnt(input logic [NumChannels-1:0] m);
    logic [IW-1:0] c;
    c = '0;
    for (int i = 0; i < NumChannels; i++) c = c + IW'(m[i]);
    return c;
  endfunction

  assign w_k      = popcnt(r_mask);
  assign w_k_live = popcnt(cfg_ch_en_i);
  assign w_last   = ((r_idx + w_k) >= NW);
  assign w_accept = data_in_ready_o && (&data_in_valid_i);

  // Enabled channels take consecutive words starting at idx, lowest channel first.
  always_comb begin
    w_data  = '0;
    w_valid = '0;
    w_slot  = '0;
    w_word  = '0;
    if (r_state == SEND) begin
      w_valid = r_mask;
      for (int ch = 0; ch < NumChannels; ch++) begin
        if (r_mask[ch]) begin
          w_word = r_idx + w_slot;
          if (w_word < NW) w_data[ch] = r_hold[w_word[LW-1:0]];
          w_slot = w_slot + IW'(1);
        end
      end
    end
  end

  always_comb begin
    data_in_ready_o  = 1'b0;
    data_out_o       = w_data;
    data_out_valid_o = w_valid;
    if (cfg_bypass_i) begin
      data_out_o       = data_in_i;
      data_out_valid_o = data_in_valid_i;
      data_in_ready_o  = data_out_ready_i;
    end else if (!cfg_flush_i) begin
      if (r_state == IDLE) data_in_ready_o = (w_k_live != '0);
      else                 data_in_ready_o = w_last && data_out_ready_i && (w_k_live != '0);
    end
  end

  // Bypass and flush both abandon any held beat; a new beat can be taken on the last send cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mask  <= '0;
      r_hold  <= '0;
    end else if (cfg_bypass_i || cfg_flush_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mask  <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SEND;
            r_idx   <= '0;
            r_mask  <= cfg_ch_en_i;
            r_hold  <= data_in_i;
          end
        end
        SEND: begin
          if (data_out_ready_i) begin
            if (w_last) begin
              r_idx <= '0;
              if (w_accept) begin
                r_mask <= cfg_ch_en_i;
                r_hold <= data_in_i;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_idx <= r_idx + w_k;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
